// File: rtl/fp_to_pcm16.sv
// fp_to_pcm16
// Converts one IEEE-754 single-precision sample in [-1.0, 1.0) into a signed
// 16-bit PCM word. The mantissa is shifted right one bit per cycle, so a
// conversion takes 11..26 cycles on the normal path. Special values (NaN,
// out-of-range, tiny, zero) resolve in a single cycle.
//
// Optional feature macro: FP2PCM_ROUND_EN
//   defined   : round-half-up on magnitude (symmetric about zero)
//   undefined : truncate toward zero
//
// Ports
//   clk        in   1   clock, posedge
//   reset      in   1   synchronous, active-high reset
//   in_data    in  32   float sample {sign, exp[7:0], mant[22:0]}
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepts input (IDLE only)
//   out_data   out 16   signed two's-complement PCM sample
//   out_valid  out  1   out_data valid, held until accepted
//   out_ready  in   1   downstream accepts out_data
module fp_to_pcm16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

`ifdef FP2PCM_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  state_t      state_r, state_n;
  logic [23:0] mag_r, mag_n;
  logic        r_r, r_n;
  logic [4:0]  cnt_r, cnt_n;
  logic        sign_r, sign_n;
  logic [15:0] out_data_r, out_data_n;
  logic        out_valid_r;
  logic        in_ready_r;

  logic        sign_s;
  logic [7:0]  exp_s;
  logic [22:0] mant_s;
  logic        rnd_s;
  logic [16:0] sum_s;
  logic [15:0] result_s;

  assign sign_s = in_data[31];
  assign exp_s  = in_data[30:23];
  assign mant_s = in_data[22:0];

  // Rounded magnitude and its signed, clamped PCM encoding.
  always_comb begin
    rnd_s    = r_r & ROUND_EN;
    sum_s    = {1'b0, mag_r[15:0]} + {16'd0, rnd_s};
    result_s = 16'h0000;
    if (sign_r == 1'b0) begin
      // +32768 is not representable; clamp to full-scale positive.
      if (sum_s == 17'd32768) begin
        result_s = 16'h7FFF;
      end else begin
        result_s = sum_s[15:0];
      end
    end else begin
      // Two's-complement negate; 32768 maps to 16'h8000 and 0 stays 0.
      result_s = (~sum_s[15:0]) + 16'd1;
    end
  end

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_n    = state_r;
    mag_n      = mag_r;
    r_n        = r_r;
    cnt_n      = cnt_r;
    sign_n     = sign_r;
    out_data_n = out_data_r;
    case (state_r)
      IDLE: begin
        if (in_valid == 1'b1) begin
          sign_n  = sign_s;
          state_n = HOLD;
          if ((exp_s == 8'd255) && (mant_s != 23'd0)) begin
            out_data_n = 16'h0000;
          end else if (exp_s >= 8'd127) begin
            out_data_n = sign_s ? 16'h8000 : 16'h7FFF;
          end else if (exp_s < 8'd111) begin
            out_data_n = 16'h0000;
          end else begin
            mag_n   = {1'b1, mant_s};
            r_n     = 1'b0;
            // 135 - e fits in 9..24 here; 135 mod 32 = 7, so 5-bit math suffices.
            cnt_n   = 5'd7 - exp_s[4:0];
            state_n = SHIFT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        r_n   = mag_r[0];
        mag_n = {1'b0, mag_r[23:1]};
        cnt_n = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_n = ROUND;
        end else begin
          state_n = SHIFT;
        end
      end
      ROUND: begin
        out_data_n = result_s;
        state_n    = HOLD;
      end
      HOLD: begin
        if (out_ready == 1'b1) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mag_r       <= 24'd0;
      r_r         <= 1'b0;
      cnt_r       <= 5'd0;
      sign_r      <= 1'b0;
      out_data_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_n;
      mag_r       <= mag_n;
      r_r         <= r_n;
      cnt_r       <= cnt_n;
      sign_r      <= sign_n;
      out_data_r  <= out_data_n;
      out_valid_r <= (state_n == HOLD);
      in_ready_r  <= (state_n == IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fp_to_pcm16.sv
module tb_fp_to_pcm16;

`ifdef FP2PCM_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  fp_to_pcm16 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: value * 32768 computed in real arithmetic, then rounded or truncated.
  function automatic logic [15:0] ref_pcm(input logic [31:0] f);
    int  e;
    int  mag;
    real v;
    e = int'(f[30:23]);
    if (e == 255 && f[22:0] != 23'd0) return 16'h0000;
    if (e >= 127) return f[31] ? 16'h8000 : 16'h7FFF;
    if (e < 111) return 16'h0000;
    v = 8388608.0 + real'(f[22:0]);
    for (int i = 0; i < 135 - e; i++) v = v / 2.0;
    mag = ROUND_EN ? int'($floor(v + 0.5)) : int'($floor(v));
    if (!f[31]) return (mag > 32767) ? 16'h7FFF : 16'(mag);
    return 16'(-mag);
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int e;
    e = int'(f[30:23]);
    if (e >= 127 || e < 111) return 1;
    return 137 - e;
  endfunction

  // Full handshake for one sample; returns result and accept-to-valid latency.
  task automatic run_sample(input logic [31:0] d, input string tag,
                            output logic [15:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 60) begin step(); w++; end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin step(); lat++; end
    res = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " release"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  task automatic sample_check(input logic [31:0] d, input string tag,
                              input logic [15:0] exp_val, input int exp_lat);
    logic [15:0] res;
    int lat;
    run_sample(d, tag, res, lat);
    check({tag, " data"}, 32'(res), 32'(exp_val));
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [15:0] held;
    logic [31:0] d;
    int bad;
    int w;

    reset = 1'b1; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    step();

    // Directed cases
    sample_check(32'h3F000000, "half",     16'h4000, 11);
    sample_check(32'hBE800000, "neg_qtr",  16'hE000, 12);
    sample_check(32'h3F800000, "one",      16'h7FFF, 1);
    sample_check(32'hBF800000, "neg_one",  16'h8000, 1);
    sample_check(32'h7F800000, "pinf",     16'h7FFF, 1);
    sample_check(32'h7FC00000, "nan",      16'h0000, 1);
    sample_check(32'h80000000, "neg_zero", 16'h0000, 1);
    sample_check(32'h00400000, "denorm",   16'h0000, 1);
    sample_check(32'h38400000, "round",    ROUND_EN ? 16'h0002 : 16'h0001, 25);
    sample_check(32'hB8400000, "nround",   ROUND_EN ? 16'hFFFE : 16'hFFFF, 25);
    sample_check(32'h3F7FFFFF, "clamp",    16'h7FFF, 11);
    sample_check(32'h37800000, "e111",     ROUND_EN ? 16'h0001 : 16'h0000, 26);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        d = $urandom;
      end else begin
        d = {1'($urandom_range(0, 1)), 8'($urandom_range(105, 130)), 23'($urandom)};
      end
      sample_check(d, $sformatf("rnd%0d_%h", i, d), ref_pcm(d), ref_lat(d));
    end

    // Backpressure with in_valid held high and new data waiting
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    step();
    in_data = 32'h3F800000;
    w = 1;
    while (!out_valid && w < 60) begin step(); w++; end
    check("bp lat", 32'(w), 32'd11);
    held = out_data;
    check("bp data", 32'(held), 32'h4000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("bp stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp idle", {30'd0, in_ready, out_valid}, 32'd2);
    step();
    in_valid = 1'b0;
    check("bp next valid", 32'(out_valid), 32'd1);
    check("bp next data", 32'(out_data), 32'h7FFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during SHIFT
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst flags", {30'd0, out_valid, in_ready}, 32'd1);
    check("mid_rst data", 32'(out_data), 32'd0);
    sample_check(32'h3E800000, "post_rst", 16'h2000, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
